// File: rtl/gpcfg_access_arb.sv
// gpcfg_access_arb: two-port round-robin access arbiter and sequencer for the
// gpcfg register bank. Serialises the AHB-side port (m0) and the internal
// configuration sequencer port (m1), drives the bank write strobe and the
// read-data mux valid, and returns the registered readback to the winner.
module gpcfg_access_arb #(
  parameter int ADDR_W   = 10,
  parameter int NUM_REGS = 1024,
  parameter int DATA_W   = 32
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic [ADDR_W-1:0] cfg_addr,
  output logic              cfg_we,
  output logic [DATA_W-1:0] cfg_wdata,
  output logic              cfg_rd,
  input  logic [DATA_W-1:0] cfg_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    CAP  = 2'd3
  } state_t;

  // Addresses are zero-extended to 32 bits before the range compare so the
  // limit may equal 2**ADDR_W (every address valid) without overflow.
  localparam int unsigned NUM_REGS_U = NUM_REGS;

  state_t              state_q, state_d;
  logic                last_q, last_d;      // port that won the previous grant
  logic                owner_q, owner_d;    // port owning the access in flight
  logic                oor_q, oor_d;        // in-flight read is out of range
  logic [1:0]          gnt_q, gnt_d;
  logic [1:0]          rvalid_q, rvalid_d;
  logic [1:0]          err_q, err_d;
  logic [DATA_W-1:0]   rdata_q [2];
  logic [DATA_W-1:0]   rdata_d [2];
  logic                cfg_we_q, cfg_we_d;
  logic                cfg_rd_q, cfg_rd_d;
  logic [ADDR_W-1:0]   cfg_addr_q, cfg_addr_d;
  logic [DATA_W-1:0]   cfg_wdata_q, cfg_wdata_d;

  logic                win_valid;
  logic                win_sel;
  logic                win_we;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;
  logic                win_oor;

  // Round-robin pick: a lone requester wins, a tie goes to the port that did
  // not win last time.
  always_comb begin
    win_valid = m0_req | m1_req;
    if (m0_req && m1_req) begin
      win_sel = ~last_q;
    end else begin
      win_sel = m1_req;
    end
    win_we    = win_sel ? m1_we    : m0_we;
    win_addr  = win_sel ? m1_addr  : m0_addr;
    win_wdata = win_sel ? m1_wdata : m0_wdata;
    win_oor   = ({{(32-ADDR_W){1'b0}}, win_addr} >= NUM_REGS_U);
  end

  // Next-state and next-output computation for the access sequencer.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    oor_d       = oor_q;
    gnt_d       = 2'b00;
    rvalid_d    = 2'b00;
    err_d       = 2'b00;
    rdata_d[0]  = '0;
    rdata_d[1]  = '0;
    cfg_we_d    = 1'b0;
    cfg_rd_d    = 1'b0;
    cfg_addr_d  = cfg_addr_q;
    cfg_wdata_d = cfg_wdata_q;

    case (state_q)
      IDLE: begin
        if (win_valid) begin
          gnt_d[win_sel] = 1'b1;
          last_d         = win_sel;
          owner_d        = win_sel;
          oor_d          = win_oor;
          cfg_addr_d     = win_addr;
          if (win_we) begin
            // Out-of-range writes are granted and flagged but never strobed.
            state_d        = WR;
            cfg_wdata_d    = win_wdata;
            cfg_we_d       = ~win_oor;
            err_d[win_sel] = win_oor;
          end else begin
            // Out-of-range reads skip the mux; the error rides to the response.
            state_d  = RD;
            cfg_rd_d = ~win_oor;
          end
        end
      end
      WR: begin
        state_d = IDLE;
      end
      RD: begin
        // The bank registers the mux output, so data is valid in CAP.
        state_d = CAP;
      end
      CAP: begin
        state_d           = IDLE;
        rvalid_d[owner_q] = 1'b1;
        err_d[owner_q]    = oor_q;
        rdata_d[owner_q]  = oor_q ? '0 : cfg_rdata;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Single state/output register bank; reset aborts any access in flight.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      oor_q       <= 1'b0;
      gnt_q       <= 2'b00;
      rvalid_q    <= 2'b00;
      err_q       <= 2'b00;
      rdata_q[0]  <= '0;
      rdata_q[1]  <= '0;
      cfg_we_q    <= 1'b0;
      cfg_rd_q    <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      oor_q       <= oor_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
      rdata_q[0]  <= rdata_d[0];
      rdata_q[1]  <= rdata_d[1];
      cfg_we_q    <= cfg_we_d;
      cfg_rd_q    <= cfg_rd_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_wdata_q <= cfg_wdata_d;
    end
  end

  assign m0_gnt    = gnt_q[0];
  assign m1_gnt    = gnt_q[1];
  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_err    = err_q[0];
  assign m1_err    = err_q[1];
  assign m0_rdata  = rdata_q[0];
  assign m1_rdata  = rdata_q[1];
  assign cfg_addr  = cfg_addr_q;
  assign cfg_we    = cfg_we_q;
  assign cfg_wdata = cfg_wdata_q;
  assign cfg_rd    = cfg_rd_q;

  // Only one port may ever be granted in a cycle.
  a_one_gnt: assert property (@(posedge hclk) disable iff (hreset) !(gnt_q[0] && gnt_q[1]));

endmodule

// File: tb/tb_gpcfg_access_arb.sv
// Testbench for gpcfg_access_arb: two instances (1024 and 1000 implemented
// registers) share one stimulus stream, each with its own register-bank and
// registered-mux model. Expected responses are queued when a request is
// presented and retired when the grant / read response appears.
module tb_gpcfg_access_arb;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int NI = 2;

  function automatic int nregs(int k);
    return (k == 0) ? 1024 : 1000;
  endfunction

  function automatic logic [DW-1:0] init_val(int i);
    if (i == 1023) return 32'h1234_5678;
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  typedef struct {
    logic                   we;
    logic [AW-1:0]          addr;
    logic [DW-1:0]          wdata;
    logic [NI-1:0][DW-1:0]  rdat;
  } req_t;

  typedef struct {
    int                     port;
    int                     due;
    logic [NI-1:0][DW-1:0]  data;
    logic [NI-1:0]          err;
  } rsp_t;

  logic            hclk = 1'b0;
  logic            hreset;
  logic [1:0]      req;
  logic [1:0]      we;
  logic [AW-1:0]   addr  [2];
  logic [DW-1:0]   wdata [2];

  logic [1:0]      gnt_w      [NI];
  logic [1:0]      rvalid_w   [NI];
  logic [1:0]      err_w      [NI];
  logic [DW-1:0]   rdata_w    [NI][2];
  logic            cfg_we_w   [NI];
  logic            cfg_rd_w   [NI];
  logic [AW-1:0]   cfg_addr_w [NI];
  logic [DW-1:0]   cfg_wdata_w[NI];
  logic [DW-1:0]   cfg_rdata_w[NI];

  always #5 hclk = ~hclk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    logic [DW-1:0] mem [1024];

    gpcfg_access_arb #(
      .ADDR_W  (AW),
      .NUM_REGS(nregs(gi)),
      .DATA_W  (DW)
    ) u_dut (
      .hclk      (hclk),
      .hreset    (hreset),
      .m0_req    (req[0]),
      .m0_we     (we[0]),
      .m0_addr   (addr[0]),
      .m0_wdata  (wdata[0]),
      .m0_gnt    (gnt_w[gi][0]),
      .m0_rvalid (rvalid_w[gi][0]),
      .m0_rdata  (rdata_w[gi][0]),
      .m0_err    (err_w[gi][0]),
      .m1_req    (req[1]),
      .m1_we     (we[1]),
      .m1_addr   (addr[1]),
      .m1_wdata  (wdata[1]),
      .m1_gnt    (gnt_w[gi][1]),
      .m1_rvalid (rvalid_w[gi][1]),
      .m1_rdata  (rdata_w[gi][1]),
      .m1_err    (err_w[gi][1]),
      .cfg_addr  (cfg_addr_w[gi]),
      .cfg_we    (cfg_we_w[gi]),
      .cfg_wdata (cfg_wdata_w[gi]),
      .cfg_rd    (cfg_rd_w[gi]),
      .cfg_rdata (cfg_rdata_w[gi])
    );

    // Register bank plus registered OR-mux: output is 0 unless cfg_rd was high.
    always @(posedge hclk) begin
      if (hreset) begin
        for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
        cfg_rdata_w[gi] <= '0;
      end else begin
        if (cfg_we_w[gi]) mem[cfg_addr_w[gi]] <= cfg_wdata_w[gi];
        cfg_rdata_w[gi] <= cfg_rd_w[gi] ? mem[cfg_addr_w[gi]] : '0;
      end
    end
  end

  int            cyc;
  int            n_checks;
  int            n_fail;
  int            pred_cyc;
  int            pred_port;
  int            idle_at;
  logic          mlast;
  logic [1:0]    granted_now;
  logic [DW-1:0] shadow   [NI][1024];
  logic [AW-1:0] exp_addr [NI];
  logic [DW-1:0] exp_wd   [NI];
  req_t          stim_q [2][$];
  req_t          exp_q  [2][$];
  rsp_t          rd_q [$];
  int            glog_port [$];
  int            glog_cyc  [$];

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic push_req(int p, logic w, int a, logic [DW-1:0] d);
    req_t e;
    e.we    = w;
    e.addr  = AW'(a);
    e.wdata = d;
    e.rdat  = '0;
    stim_q[p].push_back(e);
  endtask

  // Compare every DUT output of both instances against the expectations for
  // this cycle and retire scoreboard entries on grants / responses.
  task automatic check_cycle();
    rsp_t                       rsp;
    req_t                       e;
    logic [1:0]                 exp_g;
    logic [NI-1:0]              exp_we, exp_rd;
    logic [NI-1:0][1:0]         exp_err, exp_rv;
    logic [NI-1:0][1:0][DW-1:0] exp_rdata;
    logic                       oor;
    exp_we = '0; exp_rd = '0; exp_err = '0; exp_rv = '0; exp_rdata = '0;
    exp_g  = (pred_cyc == cyc) ? 2'(1 << pred_port) : 2'b00;

    if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      rsp = rd_q.pop_front();
      for (int k = 0; k < NI; k++) begin
        exp_rv[k][rsp.port]    = 1'b1;
        exp_rdata[k][rsp.port] = rsp.data[k];
        exp_err[k][rsp.port]   = rsp.err[k];
      end
    end

    for (int p = 0; p < 2; p++) begin
      if (gnt_w[0][p]) begin
        glog_port.push_back(p);
        glog_cyc.push_back(cyc);
      end
      if (exp_g[p] && exp_q[p].size() > 0) begin
        e = exp_q[p].pop_front();
        $display("txn cyc=%0d port=m%0d %s addr=0x%03h wdata=0x%08h", cyc, p,
                 e.we ? "WR" : "RD", e.addr, e.wdata);
        for (int k = 0; k < NI; k++) begin
          oor         = (int'(e.addr) >= nregs(k));
          exp_we[k]   = e.we & ~oor;
          exp_rd[k]   = ~e.we & ~oor;
          exp_addr[k] = e.addr;
          if (e.we) begin
            exp_wd[k]     = e.wdata;
            exp_err[k][p] = oor;
          end
        end
        if (!e.we) begin
          rsp.port = p;
          rsp.due  = cyc + 2;
          for (int k = 0; k < NI; k++) begin
            rsp.err[k]  = (int'(e.addr) >= nregs(k));
            rsp.data[k] = rsp.err[k] ? '0 : e.rdat[k];
          end
          rd_q.push_back(rsp);
        end
      end
    end
    granted_now = exp_g;

    for (int k = 0; k < NI; k++) begin
      check_eq($sformatf("i%0d_gnt", k),       64'(gnt_w[k]),       64'(exp_g));
      check_eq($sformatf("i%0d_cfg_we", k),    64'(cfg_we_w[k]),    64'(exp_we[k]));
      check_eq($sformatf("i%0d_cfg_rd", k),    64'(cfg_rd_w[k]),    64'(exp_rd[k]));
      check_eq($sformatf("i%0d_cfg_addr", k),  64'(cfg_addr_w[k]),  64'(exp_addr[k]));
      check_eq($sformatf("i%0d_cfg_wdata", k), 64'(cfg_wdata_w[k]), 64'(exp_wd[k]));
      check_eq($sformatf("i%0d_err", k),       64'(err_w[k]),       64'(exp_err[k]));
      check_eq($sformatf("i%0d_rvalid", k),    64'(rvalid_w[k]),    64'(exp_rv[k]));
      check_eq($sformatf("i%0d_m0_rdata", k),  64'(rdata_w[k][0]),  64'(exp_rdata[k][0]));
      check_eq($sformatf("i%0d_m1_rdata", k),  64'(rdata_w[k][1]),  64'(exp_rdata[k][1]));
    end
  endtask

  // Requester behaviour: drop req on grant, present the next queued request.
  task automatic drive();
    req_t e;
    for (int p = 0; p < 2; p++) begin
      if (granted_now[p]) req[p] = 1'b0;
      if (!req[p] && stim_q[p].size() > 0) begin
        e = stim_q[p].pop_front();
        for (int k = 0; k < NI; k++) begin
          e.rdat[k] = shadow[k][e.addr];
          if (e.we && int'(e.addr) < nregs(k)) shadow[k][e.addr] = e.wdata;
        end
        exp_q[p].push_back(e);
        req[p]   = 1'b1;
        we[p]    = e.we;
        addr[p]  = e.addr;
        wdata[p] = e.wdata;
      end
    end
  endtask

  // Timing model of the arbiter: when it is idle and a request is up, the
  // winner is granted next cycle; write holds it 2 cycles, read 3.
  task automatic predict();
    logic w;
    if (!hreset && cyc >= idle_at && req != 2'b00) begin
      w         = (req == 2'b11) ? ~mlast : req[1];
      pred_cyc  = cyc + 1;
      pred_port = int'(w);
      mlast     = w;
      idle_at   = cyc + (we[w] ? 2 : 3);
    end
  endtask

  task automatic step();
    @(negedge hclk);
    cyc++;
    check_cycle();
    drive();
    predict();
  endtask

  task automatic apply_reset(int ncyc);
    hreset = 1'b1;
    req    = 2'b00;
    for (int p = 0; p < 2; p++) begin
      stim_q[p].delete();
      exp_q[p].delete();
    end
    rd_q.delete();
    pred_cyc    = -1;
    idle_at     = 0;
    mlast       = 1'b1;
    granted_now = 2'b00;
    for (int k = 0; k < NI; k++) begin
      exp_addr[k] = '0;
      exp_wd[k]   = '0;
      for (int i = 0; i < 1024; i++) shadow[k][i] = init_val(i);
    end
    repeat (ncyc) step();
    hreset = 1'b0;
  endtask

  function automatic logic busy();
    return (stim_q[0].size() + stim_q[1].size() + exp_q[0].size() + exp_q[1].size()
            + rd_q.size()) != 0 || req != 2'b00;
  endfunction

  task automatic run_until_done(int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    check_eq("drain_timeout", 64'(busy()), 64'd0);
    repeat (2) step();
  endtask

  task automatic clear_log();
    glog_port.delete();
    glog_cyc.delete();
  endtask

  initial begin
    int t0;
    cyc = 0; n_checks = 0; n_fail = 0;
    we = 2'b00;
    for (int p = 0; p < 2; p++) begin
      addr[p]  = '0;
      wdata[p] = '0;
    end
    apply_reset(3);

    // Single write from m0.
    clear_log();
    t0 = cyc + 1;
    push_req(0, 1'b1, 'h005, 32'hDEAD_BEEF);
    run_until_done(50);
    check_eq("wr_gnt_count", 64'(glog_port.size()), 64'd1);
    if (glog_cyc.size() > 0) check_eq("wr_gnt_latency", 64'(glog_cyc[0] - t0), 64'd1);

    // Single read from m1 of the top register.
    clear_log();
    t0 = cyc + 1;
    push_req(1, 1'b0, 'h3FF, '0);
    run_until_done(50);
    check_eq("rd_gnt_count", 64'(glog_port.size()), 64'd1);
    if (glog_cyc.size() > 0) check_eq("rd_gnt_latency", 64'(glog_cyc[0] - t0), 64'd1);

    // Contention from reset: both ports stream 4 writes.
    apply_reset(2);
    clear_log();
    for (int i = 0; i < 4; i++) begin
      push_req(0, 1'b1, 'h10 + i, 32'hA000_0000 + 32'(i));
      push_req(1, 1'b1, 'h20 + i, 32'hB000_0000 + 32'(i));
    end
    run_until_done(100);
    check_eq("cont_gnt_count", 64'(glog_port.size()), 64'd8);
    for (int i = 0; i < glog_port.size(); i++) begin
      check_eq($sformatf("cont_order_%0d", i), 64'(glog_port[i]), 64'(i % 2));
      if (i > 0) check_eq($sformatf("cont_spacing_%0d", i), 64'(glog_cyc[i] - glog_cyc[i-1]), 64'd2);
    end

    // Out-of-range read and write (instance 1 implements 1000 registers).
    push_req(0, 1'b0, 1000, '0);
    run_until_done(50);
    push_req(1, 1'b1, 1023, 32'h5555_AAAA);
    run_until_done(50);
    push_req(0, 1'b0, 1023, '0);
    run_until_done(50);

    // Back-to-back read then write on m0, then read back the write.
    clear_log();
    push_req(0, 1'b0, 'h11, '0);
    push_req(0, 1'b1, 'h30, 32'h0BAD_F00D);
    push_req(0, 1'b0, 'h30, '0);
    run_until_done(100);
    check_eq("b2b_gnt_count", 64'(glog_port.size()), 64'd3);
    if (glog_cyc.size() > 1) check_eq("b2b_wr_after_rd", 64'(glog_cyc[1] - glog_cyc[0]), 64'd3);

    // Reset during the CAP cycle of an m0 read: no response, tie then to m0.
    clear_log();
    push_req(0, 1'b0, 'h12, '0);
    for (int n = 0; n < 20 && glog_port.size() == 0; n++) step();
    check_eq("rst_rd_gnt_seen", 64'(glog_port.size()), 64'd1);
    step();
    apply_reset(2);
    repeat (4) step();
    clear_log();
    push_req(0, 1'b1, 'h40, 32'h1111_1111);
    push_req(1, 1'b1, 'h41, 32'h2222_2222);
    run_until_done(50);
    check_eq("rst_tie_count", 64'(glog_port.size()), 64'd2);
    if (glog_port.size() > 0) check_eq("rst_tie_winner", 64'(glog_port[0]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
